// File: rtl/euclidean_distance_nf.sv
// -----------------------------------------------------------------------------
// euclidean_distance_nf
//   Distance cell for the DTW datapath. Takes NUM_F signed features from a
//   template vector and a test vector and produces
//   floor(sqrt(sum_k (template_k - test_k)^2)). When ROOT_EN=0 it produces the
//   raw squared sum instead, and the root stage is never entered.
//   The root is computed with a multicycle non-restoring digit-by-digit
//   algorithm: one root bit per clock.
//
// Ports
//   clk            rising-edge system clock
//   rst_n          asynchronous active-low reset
//   template_data  packed template features, feature 0 in the MSBs
//   test_data      packed test features, same packing
//   in_valid       operands valid
//   in_ready       block idle and able to accept operands
//   out_data       distance (root, or squared sum when ROOT_EN=0)
//   out_sum        squared sum, valid alongside out_data
//   out_valid      result valid, held until out_ready
//   out_ready      downstream accepts the result
// -----------------------------------------------------------------------------
module euclidean_distance_nf #(
   parameter  int NUM_F   = 2,
   parameter  int FW      = 16,
   parameter  int ROOT_EN = 1,
   localparam int N       = NUM_F * FW,
   localparam int SW      = 2 * FW + 1 + $clog2(NUM_F),
   localparam int RW      = (SW + 1) / 2,
   localparam int OW      = (ROOT_EN != 0) ? RW : SW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  template_data,
   input  logic [N-1:0]  test_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [OW-1:0] out_data,
   output logic [SW-1:0] out_sum,
   output logic          out_valid,
   input  logic          out_ready
);

   localparam int SQW  = 2 * FW + 1;          // width of one squared difference
   localparam int RADW = 2 * RW;              // radicand, padded to an even width
   localparam int RRW  = RW + 4;              // partial remainder, signed, with headroom
   localparam int CW   = (RW > 1) ? $clog2(RW) : 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DIFF = 3'd1,
      SUM  = 3'd2,
      SQRT = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t                state_r;
   state_t                state_nx_s;

   logic [N-1:0]          tmpl_r;
   logic [N-1:0]          test_r;
   logic signed [FW:0]    diff_s [NUM_F];
   logic signed [FW:0]    diff_r [NUM_F];
   logic [SW-1:0]         sum_s;
   logic [SW-1:0]         sum_r;
   logic [RADW-1:0]       rad_r;
   logic signed [RRW-1:0] rem_r;
   logic signed [RRW-1:0] rem_sh_s;
   logic signed [RRW-1:0] rem_nx_s;
   logic [RW-1:0]         root_r;
   logic [RW-1:0]         root_nx_s;
   logic [CW-1:0]         cnt_r;
   logic [OW-1:0]         result_s;
   logic                  accept_s;
   logic                  release_s;

   assign accept_s  = in_valid && in_ready;
   assign release_s = out_valid && out_ready;

   // Per-feature differences, each feature sign-extended by one bit so that
   // the full range (e.g. 0x7FFF - 0x8000) fits without overflow.
   always_comb begin
      diff_s = '{default: '0};
      for (int k = 0; k < NUM_F; k++) begin
         diff_s[k] = $signed({tmpl_r[N-1-k*FW], tmpl_r[N-1-k*FW -: FW]})
                   - $signed({test_r[N-1-k*FW], test_r[N-1-k*FW -: FW]});
      end
   end

   // Sum of squares. |diff| <= 2^FW-1, so each square fits SQW bits and the
   // sum of NUM_F of them fits SW bits.
   always_comb begin
      logic [FW:0]     mag_v;
      logic [SQW-1:0]  sq_v;
      mag_v = '0;
      sq_v  = '0;
      sum_s = '0;
      for (int k = 0; k < NUM_F; k++) begin
         if (diff_r[k][FW]) begin
            mag_v = -diff_r[k];
         end else begin
            mag_v = diff_r[k];
         end
         sq_v  = SQW'(mag_v) * SQW'(mag_v);
         sum_s = sum_s + SW'(sq_v);
      end
   end

   // One non-restoring root step: bring down two radicand bits, then subtract
   // (4q+1) when the remainder is non-negative or add (4q+3) when negative.
   // The new root bit is 1 exactly when the new remainder is non-negative.
   always_comb begin
      rem_sh_s = (rem_r <<< 2) | RRW'(rad_r[RADW-1 -: 2]);
      if (rem_r[RRW-1]) begin
         rem_nx_s = rem_sh_s + RRW'({root_r, 2'b11});
      end else begin
         rem_nx_s = rem_sh_s - RRW'({root_r, 2'b01});
      end
      root_nx_s = {root_r[RW-2:0], ~rem_nx_s[RRW-1]};
   end

   // Select the value presented on out_data.
   always_comb begin
      if (ROOT_EN != 0) begin
         result_s = OW'(root_r);
      end else begin
         result_s = OW'(sum_r);
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nx_s = DIFF;
            end else begin
               state_nx_s = IDLE;
            end
         end
         DIFF: state_nx_s = SUM;
         SUM: begin
            if (ROOT_EN != 0) begin
               state_nx_s = SQRT;
            end else begin
               state_nx_s = DONE;
            end
         end
         SQRT: begin
            if (cnt_r == '0) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = SQRT;
            end
         end
         DONE: begin
            if (release_s) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Datapath registers: operand capture, differences, sum and root iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmpl_r <= '0;
         test_r <= '0;
         for (int k = 0; k < NUM_F; k++) begin
            diff_r[k] <= '0;
         end
         sum_r  <= '0;
         rad_r  <= '0;
         rem_r  <= '0;
         root_r <= '0;
         cnt_r  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  tmpl_r <= template_data;
                  test_r <= test_data;
               end
            end
            DIFF: begin
               for (int k = 0; k < NUM_F; k++) begin
                  diff_r[k] <= diff_s[k];
               end
            end
            SUM: begin
               sum_r  <= sum_s;
               rad_r  <= RADW'(sum_s);
               rem_r  <= '0;
               root_r <= '0;
               cnt_r  <= CW'(RW - 1);
            end
            SQRT: begin
               rad_r  <= rad_r << 2;
               rem_r  <= rem_nx_s;
               root_r <= root_nx_s;
               cnt_r  <= cnt_r - CW'(1);
            end
            DONE: begin
               sum_r <= sum_r;
            end
            default: begin
               cnt_r <= '0;
            end
         endcase
      end
   end

   // Output registers. The first DONE cycle loads the result and raises
   // out_valid; it then holds until the handshake. in_ready tracks IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sum   <= '0;
      end else begin
         in_ready <= (state_nx_s == IDLE);
         if ((state_r == DONE) && !out_valid) begin
            out_valid <= 1'b1;
            out_data  <= result_s;
            out_sum   <= sum_r;
         end else if (release_s) begin
            out_valid <= 1'b0;
         end else begin
            out_valid <= out_valid;
         end
      end
   end

endmodule

// File: tb/tb_euclidean_distance_nf.sv
// -----------------------------------------------------------------------------
// tb_euclidean_distance_nf
//   Two instances: A (NUM_F=2, FW=16, root enabled) and B (NUM_F=4, FW=8,
//   squared sum only). Directed cases plus random vectors, each compared with
//   a plain-arithmetic reference model of the squared sum and floor root.
// -----------------------------------------------------------------------------
module tb_euclidean_distance_nf;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [31:0] a_tmpl, a_test;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [16:0] a_out_data;
   logic [33:0] a_out_sum;

   logic [31:0] b_tmpl, b_test;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [18:0] b_out_data;
   logic [18:0] b_out_sum;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   euclidean_distance_nf dut_a (
      .clk(clk), .rst_n(rst_n),
      .template_data(a_tmpl), .test_data(a_test),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_data(a_out_data), .out_sum(a_out_sum),
      .out_valid(a_out_valid), .out_ready(a_out_ready)
   );

   euclidean_distance_nf #(.NUM_F(4), .FW(8), .ROOT_EN(0)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .template_data(b_tmpl), .test_data(b_test),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_data(b_out_data), .out_sum(b_out_sum),
      .out_valid(b_out_valid), .out_ready(b_out_ready)
   );

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: sum of squared feature differences, feature 0 in the MSBs.
   function automatic longint ref_sum(input logic [31:0] tm, input logic [31:0] ts,
                                      input int nf, input int fw);
      longint acc, a, b, m;
      acc = 0;
      m   = (longint'(1) << fw) - 1;
      for (int k = 0; k < nf; k++) begin
         a = longint'(tm >> ((nf - 1 - k) * fw)) & m;
         b = longint'(ts >> ((nf - 1 - k) * fw)) & m;
         if (a > (m >> 1)) a = a - (m + 1);
         if (b > (m >> 1)) b = b - (m + 1);
         acc = acc + (a - b) * (a - b);
      end
      return acc;
   endfunction

   // Reference: floor square root via floating point, then exact correction.
   function automatic longint ref_root(input longint s);
      longint r;
      r = longint'($sqrt(real'(s)));
      while (r * r > s) r = r - 1;
      while ((r + 1) * (r + 1) <= s) r = r + 1;
      return r;
   endfunction

   function automatic logic [31:0] rnd_word();
      logic [31:0] pat [6];
      pat[0] = 32'h7FFF7FFF; pat[1] = 32'h80008000; pat[2] = 32'h7F7F7F7F;
      pat[3] = 32'h80808080; pat[4] = 32'h00000000; pat[5] = 32'hFFFFFFFF;
      if ($urandom_range(0, 7) == 0) return pat[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   // One transaction on A; called and returns #1 after a rising edge.
   task automatic run_a(input string tag, input logic [31:0] tm, input logic [31:0] ts,
                        input longint es, input longint er, input int hold);
      int lat;
      check_val({tag, ":in_ready"}, longint'(a_in_ready), 64'd1);
      a_tmpl = tm; a_test = ts; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      lat = 0;
      while (!a_out_valid && lat < 100) begin
         a_out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
      end
      a_out_ready = 1'b0;
      check_val({tag, ":latency"}, longint'(lat), 64'd20);
      check_val({tag, ":sum"}, longint'(a_out_sum), es);
      check_val({tag, ":data"}, longint'(a_out_data), er);
      for (int i = 0; i < hold; i++) begin
         a_in_valid = 1'b1; a_tmpl = $urandom; a_test = $urandom;
         @(posedge clk); #1;
         check_val({tag, ":hold_valid"}, longint'(a_out_valid), 64'd1);
         check_val({tag, ":hold_ready"}, longint'(a_in_ready), 64'd0);
         check_val({tag, ":hold_data"}, longint'(a_out_data), er);
      end
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_out_ready = 1'b0;
      check_val({tag, ":valid_fall"}, longint'(a_out_valid), 64'd0);
      check_val({tag, ":ready_rise"}, longint'(a_in_ready), 64'd1);
   endtask

   // One transaction on B; called and returns #1 after a rising edge.
   task automatic run_b(input string tag, input logic [31:0] tm, input logic [31:0] ts,
                        input longint es, input int hold);
      int lat;
      check_val({tag, ":in_ready"}, longint'(b_in_ready), 64'd1);
      b_tmpl = tm; b_test = ts; b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      lat = 0;
      while (!b_out_valid && lat < 100) begin
         b_out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
      end
      b_out_ready = 1'b0;
      check_val({tag, ":latency"}, longint'(lat), 64'd3);
      check_val({tag, ":sum"}, longint'(b_out_sum), es);
      check_val({tag, ":data"}, longint'(b_out_data), es);
      for (int i = 0; i < hold; i++) begin
         b_in_valid = 1'b1; b_tmpl = $urandom; b_test = $urandom;
         @(posedge clk); #1;
         check_val({tag, ":hold_valid"}, longint'(b_out_valid), 64'd1);
         check_val({tag, ":hold_ready"}, longint'(b_in_ready), 64'd0);
         check_val({tag, ":hold_data"}, longint'(b_out_data), es);
      end
      b_in_valid = 1'b0;
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
      check_val({tag, ":valid_fall"}, longint'(b_out_valid), 64'd0);
      check_val({tag, ":ready_rise"}, longint'(b_in_ready), 64'd1);
   endtask

   initial begin
      logic [31:0] tm, ts;
      longint      es;
      int          seen;
      int          hold;

      rst_n = 1'b0;
      a_tmpl = '0; a_test = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
      b_tmpl = '0; b_test = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset:a_in_ready", longint'(a_in_ready), 64'd1);
      check_val("reset:a_out_valid", longint'(a_out_valid), 64'd0);
      check_val("reset:a_out_data", longint'(a_out_data), 64'd0);
      check_val("reset:a_out_sum", longint'(a_out_sum), 64'd0);
      check_val("reset:b_in_ready", longint'(b_in_ready), 64'd1);
      check_val("reset:b_out_valid", longint'(b_out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases on A.
      run_a("a_3_4",   {16'd3, 16'd4},       32'd0, 64'd25, 64'd5, 0);
      run_a("a_neg",   {16'hFFFD, 16'hFFFC}, 32'd0, 64'd25, 64'd5, 0);
      run_a("a_5_1",   {16'd5, 16'd1},       32'd0, 64'd26, 64'd5, 0);
      run_a("a_4_2",   {16'd4, 16'd2},       32'd0, 64'd20, 64'd4, 0);
      run_a("a_equal", {16'h1234, 16'hABCD}, {16'h1234, 16'hABCD}, 64'd0, 64'd0, 0);
      run_a("a_bp",    {16'd3, 16'd4},       32'd0, 64'd25, 64'd5, 10);
      run_a("a_ext",   {16'h7FFF, 16'h7FFF}, {16'h8000, 16'h8000},
            64'd8589672450, 64'd92680, 0);

      // Reset in the middle of the root iteration.
      a_tmpl = {16'd3, 16'd4}; a_test = 32'd0; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_rst:a_in_ready", longint'(a_in_ready), 64'd1);
      check_val("mid_rst:a_out_valid", longint'(a_out_valid), 64'd0);
      check_val("mid_rst:a_out_data", longint'(a_out_data), 64'd0);
      check_val("mid_rst:a_out_sum", longint'(a_out_sum), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("mid_rst:ready_after", longint'(a_in_ready), 64'd1);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (a_out_valid) seen++;
      end
      check_val("mid_rst:no_result", longint'(seen), 64'd0);
      run_a("a_post_rst", {16'd3, 16'd4}, 32'd0, 64'd25, 64'd5, 0);

      // Directed cases on B.
      run_b("b_1234", {8'd1, 8'd2, 8'd3, 8'd4}, 32'd0, 64'd30, 0);
      run_b("b_ext",  32'h7F7F7F7F, 32'h80808080, 64'd260100, 3);

      // Random regression, both configurations.
      for (int n = 0; n < 1000; n++) begin
         tm = rnd_word(); ts = rnd_word();
         es = ref_sum(tm, ts, 2, 16);
         hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
         run_a("a_rand", tm, ts, es, ref_root(es), hold);
      end
      for (int n = 0; n < 1000; n++) begin
         tm = rnd_word(); ts = rnd_word();
         es = ref_sum(tm, ts, 4, 8);
         hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
         run_b("b_rand", tm, ts, es, hold);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/euclidean_distance_nf.md
Name: euclidean_distance_nf

Overview:
- Parametrised successor to the fixed two-feature distance cell in the DTW datapath. Computes floor(sqrt(sum over NUM_F of (template_f - test_f)^2)), or the raw squared sum when ROOT_EN=0, for NUM_F signed features packed into one word.
- Uses a valid/ready handshake and a multicycle digit-by-digit integer square root in place of vendor CORDIC/DSP IP.
- Sits between the template/test feature buffers and the DTW cost-matrix cell.

Parameters:
- NUM_F, 2, number of features per vector (>=1).
- FW, 16, feature width in bits, signed two's complement.
- ROOT_EN, 1, 1 = output the floor square root; 0 = output the squared sum and bypass the root stage.
- Derived: N = NUM_F*FW; SW = 2*FW+1+clog2(NUM_F) (sum width); RW = (SW+1)/2 (root width); OW = ROOT_EN ? RW : SW.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- template_data  in  N  packed template features; feature 0 in MSBs [N-1:N-FW], feature k in [N-1-k*FW : N-(k+1)*FW].
- test_data  in  N  packed test features, same packing.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept operands.
- out_data  out  OW  distance result.
- out_sum  out  SW  squared sum, valid alongside out_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Interface decided: one clock clk; rst_n asynchronous, active-low; all state registers clear immediately on rst_n low.
- Reset values: state=IDLE, in_ready=1 (in_ready = state==IDLE), out_valid=0, out_data=0, out_sum=0. Inputs are ignored while rst_n is low.
- FSM states are IDLE, DIFF, SUM, SQRT, DONE.
- IDLE: accept when in_valid && in_ready. Register template_data and test_data, go to DIFF.
- DIFF (1 cycle): per-feature diff_k = template_k - test_k at FW+1 bits signed, registered.
- SUM (1 cycle): square each diff (unsigned, 2*FW+1 bits) and add all squares at SW bits with no overflow possible. Register the result into sum. Then go to SQRT if ROOT_EN=1, else to DONE.
- SQRT (exactly RW cycles): non-restoring digit-by-digit root on sum, zero-extended to 2*RW bits. Each cycle consumes 2 radicand bits MSB-first and produces 1 root bit. An iteration counter runs RW-1 down to 0 and the state exits to DONE after count 0.
- Result: root = floor(sqrt(sum)), exact for all inputs.
- DONE: out_valid=1. out_data is the root, or the sum when ROOT_EN=0; out_sum = sum. Both are held stable until out_valid && out_ready.
- On the handshake cycle the state returns to IDLE, so out_valid=0 and in_ready=1 on the next cycle. There is no same-cycle re-accept.
- Latency from accept edge to out_valid high: 2+RW+1 cycles (ROOT_EN=1) or 3 cycles (ROOT_EN=0). With FW=16, NUM_F=2: SW=34, RW=17, latency 20 cycles.
- Throughput: one transaction at a time; in_ready is low from DIFF through DONE.
- out_ready held high before DONE has no effect. in_valid while busy is not accepted and the operands are not captured.
- Reset mid-operation (any non-IDLE state): the transaction is dropped and no out_valid pulse is produced. The block is in IDLE with in_ready=1 immediately after rst_n rises.
- Boundary: identical vectors give sum=0, root=0. Maximum per-feature difference is 2^FW - 1 (e.g. 0x7FFF vs 0x8000); this must not overflow the diff, square or sum widths.
- NUM_F=1 must work: clog2(1)=0, SW=2*FW+1.

Test Plan:
- FW=16, NUM_F=2, ROOT_EN=1; template F1=3, F2=4; test 0,0 -> out_sum=25, out_data=5; out_valid rises exactly 20 cycles after accept.
- Negative features: template -3,-4 vs test 0,0 -> 25/5. Template 5,1 vs test 0,0 -> sum 26, root 5. Template 4,2 vs 0,0 -> sum 20, root 4.
- Extremes: template 0x7FFF,0x7FFF vs test 0x8000,0x8000 -> out_sum=8589672450, out_data=92680. Equal vectors -> 0/0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data and out_valid stable, in_ready=0, and new in_valid ignored. On out_ready=1, out_valid falls next cycle and in_ready rises.
- Reset: assert rst_n low for 1 cycle during SQRT iteration 8 -> outputs clear asynchronously, no result is emitted, and the next transaction (3,4 vs 0,0) returns 5 normally.
- ROOT_EN=0, NUM_F=4, FW=8: diffs 1,2,3,4 -> out_data=out_sum=30, latency 3 cycles. Random regression of 1000 vectors per configuration against a reference model of the squared sum and floor root.
